// File: rtl/demux1x4_tdm.sv
// rtl/demux1x4_tdm.sv - Time-division 1-to-4 demultiplexer with HUNT/LOCK frame alignment
module demux1x4_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    input  logic             Sync,
    input  logic             En,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q0,
    output logic             Valid,
    output logic             S1,
    output logic             S0,
    output logic             Locked,
    output logic             Err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [1:0]       slot, slot_nxt;
    logic [WIDTH-1:0] h0, h1, h2;
    logic             valid_nxt, err_nxt;
    logic             ld_h0, ld_h1, ld_h2, ld_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= HUNT;
            slot  <= 2'd0;
            h0    <= '0;
            h1    <= '0;
            h2    <= '0;
            Q0    <= '0;
            Q1    <= '0;
            Q2    <= '0;
            Q3    <= '0;
            Valid <= 1'b0;
            Err   <= 1'b0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            Valid <= valid_nxt;
            Err   <= err_nxt;
            if (ld_h0) h0 <= D;
            if (ld_h1) h1 <= D;
            if (ld_h2) h2 <= D;
            // Whole frame lands on one edge so consumers never see a mixed frame
            if (ld_q) begin
                Q3 <= D;
                Q2 <= h2;
                Q1 <= h1;
                Q0 <= h0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        if (En) begin
            case (state)
                HUNT: begin
                    if (Sync) begin
                        state_nxt = LOCK;
                        slot_nxt  = 2'd1;
                    end
                end
                LOCK: begin
                    if (Sync) begin
                        slot_nxt = 2'd1;
                    end else if (slot == 2'd0) begin
                        state_nxt = HUNT;
                        slot_nxt  = 2'd0;
                    end else begin
                        slot_nxt = slot + 2'd1;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        ld_h0     = 1'b0;
        ld_h1     = 1'b0;
        ld_h2     = 1'b0;
        ld_q      = 1'b0;
        if (En) begin
            if (state == HUNT) begin
                ld_h0 = Sync;
            end else if (Sync) begin
                // Sync anywhere but slot 0 restarts the frame at this sample
                ld_h0   = 1'b1;
                err_nxt = (slot != 2'd0);
            end else begin
                case (slot)
                    2'd0: err_nxt = 1'b1;
                    2'd1: ld_h1 = 1'b1;
                    2'd2: ld_h2 = 1'b1;
                    default: begin
                        ld_q      = 1'b1;
                        valid_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    assign Locked = (state == LOCK);
    assign S1     = slot[1];
    assign S0     = slot[0];

endmodule

// File: tb/tb_demux1x4_tdm.sv
// tb/tb_demux1x4_tdm.sv - Randomized self-checking bench for demux1x4_tdm against a frame-queue model
module tb_demux1x4_tdm;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [W-1:0] D;
    logic         Sync;
    logic         En;
    logic [W-1:0] Q3, Q2, Q1, Q0;
    logic         Valid, S1, S0, Locked, Err;

    int checks   = 0;
    int failures = 0;

    // Model: partial frame as a queue, last complete frame as an array
    logic [W-1:0] frame[$];
    logic [W-1:0] mq[4];
    bit           m_locked;
    bit           m_valid;
    bit           m_err;
    int           valid_count;

    demux1x4_tdm #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .D(D), .Sync(Sync), .En(En),
        .Q3(Q3), .Q2(Q2), .Q1(Q1), .Q0(Q0),
        .Valid(Valid), .S1(S1), .S0(S0), .Locked(Locked), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit rst, input logic [W-1:0] d, input bit sync, input bit en);
        m_valid = 0;
        m_err   = 0;
        if (!rst) begin
            frame.delete();
            for (int i = 0; i < 4; i++) mq[i] = '0;
            m_locked = 0;
        end else if (en) begin
            if (sync) begin
                if (m_locked && frame.size() != 0) m_err = 1;
                frame.delete();
                frame.push_back(d);
                m_locked = 1;
            end else if (m_locked) begin
                if (frame.size() == 0) begin
                    m_err    = 1;
                    m_locked = 0;
                end else begin
                    frame.push_back(d);
                    if (frame.size() == 4) begin
                        for (int i = 0; i < 4; i++) mq[i] = frame[i];
                        frame.delete();
                        m_valid = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit rst, input logic [W-1:0] d, input bit sync, input bit en);
        Rst  = rst;
        D    = d;
        Sync = sync;
        En   = en;
        @(posedge Clk);
        model(rst, d, sync, en);
        #1;
        if (m_valid) valid_count++;
        chk("valid",  {31'd0, Valid},  {31'd0, m_valid});
        chk("err",    {31'd0, Err},    {31'd0, m_err});
        chk("locked", {31'd0, Locked}, {31'd0, m_locked});
        chk("slot",   {30'd0, S1, S0}, m_locked ? frame.size() : 0);
        chk("q", {16'd0, Q3, Q2, Q1, Q0}, {16'd0, mq[3], mq[2], mq[1], mq[0]});
    endtask

    task automatic send_frame(input logic [W-1:0] a, b, c, e);
        step(1, a, 1, 1);
        step(1, b, 0, 1);
        step(1, c, 0, 1);
        step(1, e, 0, 1);
    endtask

    int tx_slot;
    bit s;

    initial begin
        Rst = 0; D = '0; Sync = 0; En = 0;
        valid_count = 0;
        @(negedge Clk);

        // Reset with random inputs, then unsynced samples stay in HUNT
        step(0, W'($urandom), 1'($urandom), 1'($urandom));
        step(0, W'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++) step(1, W'($urandom), 0, 1);

        // Clean frames
        valid_count = 0;
        for (int f = 0; f < 3; f++) send_frame(1, 0, 1, 1);
        chk("clean_valids", valid_count, 3);

        // Gapped En between slots 1 and 2
        valid_count = 0;
        step(1, 4'hA, 1, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, W'($urandom), 1'($urandom), 0);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        chk("gap_valids", valid_count, 1);

        // Early sync at slot 2, then slots 1..3
        step(1, 3, 1, 1);
        step(1, 5, 0, 1);
        step(1, 1, 1, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        chk("early_q0", {28'd0, Q0}, 1);

        // Missing sync at slot 0, then resync
        step(1, 7, 0, 1);
        step(1, 7, 0, 1);
        send_frame(2, 4, 6, 8);

        // Reset mid-frame
        step(1, 9, 1, 1);
        step(1, 9, 0, 1);
        step(1, 9, 0, 1);
        step(0, 9, 0, 1);
        step(1, 9, 0, 1);
        chk("rst_mid_locked", {31'd0, Locked}, 0);

        // Randomized traffic with occasional framing faults, gaps and resets
        tx_slot = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(($urandom_range(0, 199) != 0), W'($urandom), 1'($urandom), 0);
            end else begin
                s = (tx_slot == 0) ^ ($urandom_range(0, 24) == 0);
                step(($urandom_range(0, 299) != 0), W'($urandom), s, 1);
                tx_slot = (tx_slot + 1) % 4;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
